// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3-window out bundle for window_3x3_gen.
// Handshake: pixel_valid marks pixel_in (and frame_start) as accepted that cycle;
// there is no ready, the sink must take every valid pixel.
interface window_3x3_gen_if;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        frame_start;
  logic [23:0] win_top;
  logic [23:0] win_mid;
  logic [23:0] win_btm;
  logic        win_valid;
  logic [9:0]  win_row;
  logic [9:0]  win_col;
  logic        frame_done;

  modport slave (
    input  pixel_in, pixel_valid, frame_start,
    output win_top, win_mid, win_btm, win_valid, win_row, win_col, frame_done
  );

  modport master (
    output pixel_in, pixel_valid, frame_start,
    input  win_top, win_mid, win_btm, win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus three 3-byte column shift
// registers produce a registered window one cycle after each accepted pixel.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  window_3x3_gen_if.slave   io_win
);

  localparam int         AW          = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [9:0] LP_COL_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [9:0] LP_ROW_LAST = 10'(IMG_HEIGHT - 1);

  // Line buffers are never reset; rows 0/1 of every frame refill them before use.
  logic [7:0]  r_lb0 [IMG_WIDTH];
  logic [7:0]  r_lb1 [IMG_WIDTH];

  logic [9:0]  r_col;
  logic [9:0]  r_row;
  logic [23:0] r_top;
  logic [23:0] r_mid;
  logic [23:0] r_btm;
  logic        r_win_valid;
  logic        r_frame_done;
  logic [9:0]  r_win_row;
  logic [9:0]  r_win_col;

  logic          w_accept;
  logic [9:0]    w_col;
  logic [9:0]    w_row;
  logic [9:0]    w_col_nxt;
  logic [9:0]    w_row_nxt;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_lb0_rd;
  logic [7:0]    w_lb1_rd;
  logic          w_win_ok;
  logic          w_last;

  // frame_start only counts when the pixel is accepted; it forces this pixel to (0,0).
  always_comb begin
    w_accept  = io_win.pixel_valid;
    w_col     = r_col;
    w_row     = r_row;
    if (w_accept && io_win.frame_start) begin
      w_col = '0;
      w_row = '0;
    end
    w_addr    = w_col[AW-1:0];
    w_lb0_rd  = r_lb0[w_addr];
    w_lb1_rd  = r_lb1[w_addr];
    w_win_ok  = (w_row >= 10'd2) && (w_col >= 10'd2);
    w_last    = (w_row == LP_ROW_LAST) && (w_col == LP_COL_LAST);
    w_col_nxt = w_col + 10'd1;
    w_row_nxt = w_row;
    if (w_col == LP_COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == LP_ROW_LAST) ? 10'd0 : (w_row + 10'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[w_addr] <= io_win.pixel_in;
      r_lb1[w_addr] <= w_lb0_rd;
    end
  end

  // Newest column enters byte [23:16]; the oldest drops out of [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_top        <= '0;
      r_mid        <= '0;
      r_btm        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_win_row    <= '0;
      r_win_col    <= '0;
    end else begin
      r_win_valid  <= w_accept && w_win_ok;
      r_frame_done <= w_accept && w_win_ok && w_last;
      if (w_accept) begin
        r_col     <= w_col_nxt;
        r_row     <= w_row_nxt;
        r_top     <= {w_lb1_rd, r_top[23:8]};
        r_mid     <= {w_lb0_rd, r_mid[23:8]};
        r_btm     <= {io_win.pixel_in, r_btm[23:8]};
        r_win_row <= w_row - 10'd1;
        r_win_col <= w_col - 10'd1;
      end
    end
  end

  assign io_win.win_top    = r_top;
  assign io_win.win_mid    = r_mid;
  assign io_win.win_btm    = r_btm;
  assign io_win.win_valid  = r_win_valid;
  assign io_win.win_row    = r_win_row;
  assign io_win.win_col    = r_win_col;
  assign io_win.frame_done = r_frame_done;

endmodule
